seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
- Receive-side counterpart of the watch's multiplexed 7-segment display drive.
- Snoops the active-low digit-select bus and segment-data bus, one digit per clk, and decodes each segment pattern back to BCD.
- Filters transients, including blink-blank frames, and reassembles the six displayed digits (HH MM SS) into registers.
- Used for display readback and self-check, and as a bench monitor.

Parameters:
- STABLE_CNT, 2: consecutive identical samples of a digit required before its register updates (legal 1..15).
- LOST_TIMEOUT, 64: clk cycles without any valid select before link_lost asserts (legal 8..4095).

Ports:
- clk  in  1  system clock (same 1 kHz domain as display source)
- rst  in  1  reset, asynchronous, active-high
- seg_com  in  8  digit select, active-low one-hot; bit7=digit0 (h_ten) ... bit2=digit5 (s_one); bit1/bit0=digits 6/7
- seg_data  in  8  segments active-high, bit order {a,b,c,d,e,f,g,dp}
- digits  out  24  captured BCD, digit0 in [23:20] ... digit5 in [3:0]
- digit_blank  out  6  bit i set when digit i last accepted pattern was 8'h00
- time_valid  out  1  all six digits hold decimal 0-9, none blank, and value <= 23:59:59
- frame_done  out  1  one-cycle pulse, full frame captured
- upd  out  1  one-cycle pulse, any digit register changed value
- com_err  out  1  one-cycle pulse, seg_com had more than one low bit
- link_lost  out  1  level; no valid select for LOST_TIMEOUT cycles

Behaviour:
- Reset values (async):
  - digits = 24'hFFFFFF; digit_blank = 6'b111111.
  - time_valid, frame_done, upd, com_err = 0; link_lost = 1.
  - All match counters, last-pattern registers and seen mask cleared.
- Stage 1: seg_com and seg_data are registered every clk with no qualification.
- Stage 2: the registered sample is classified.
  - All-ones seg_com: idle, ignored.
  - Exactly one low bit: valid select; index = position of the low bit.
  - Two or more low bits: com_err pulses, sample is dropped, and it does not count as activity.
- Valid select of digit 6 or 7:
  - Resets the link timer.
  - No other effect.
- Valid select of digit i (0..5): pattern decode.
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6.
  - dp bit is masked before decode.
  - 8'h00 means blank.
  - Any other pattern decodes to 4'hE (illegal).
- Per-digit stability filter:
  - match_cnt[i] increments (saturating at STABLE_CNT) when the pattern equals last_pat[i].
  - Otherwise match_cnt[i] is set to 1 and last_pat[i] is loaded.
  - When match_cnt[i] reaches STABLE_CNT, the digit is accepted:
    - decimal: digits[i] <= value, digit_blank[i] <= 0;
    - blank: digits[i] holds, digit_blank[i] <= 1;
    - illegal: digits[i] <= 4'hE, digit_blank[i] <= 0.
- Latency: a sample completing stability is visible on digits 2 clk edges after the edge that captured it in stage 1.
- upd pulses in the same cycle the register changes.
  - Re-accepting the same value gives no pulse.
  - A blank transition pulses only if digit_blank[i] changes.
- Frame tracking:
  - seen mask bit i is set on each acceptance of digit i.
  - When digit 5 is accepted and the mask for digits 0..4 is all set, frame_done pulses and the mask clears.
  - Digit 5 accepted with the mask incomplete: no pulse, mask is cleared.
- time_valid is combinational from the registered digits and digit_blank.
  - Requires h_ten <= 2, h_ten:h_one <= 23, m_ten <= 5, s_ten <= 5.
- Link timer:
  - Counts clk cycles; cleared by any valid select.
  - At LOST_TIMEOUT, link_lost = 1 and the counter saturates.
  - Cleared on the next valid select, visible the cycle after stage 2.
  - Digit registers are retained while the link is lost.
- Simultaneous events: com_err and link-timer expiry in the same cycle both take effect. The dropped sample does not clear the timer.
- Reset mid-frame: everything returns to reset values immediately; the next frame must capture from scratch.

Test Plan:
- Normal frame, 12:34:56:
  - Stimulus: scan digits 0..7 cyclically, one per clk, patterns 60,DA,F2,66,B6,BE, STABLE_CNT=2.
  - Response: digits = 24'h123456 after the second scan; frame_done pulses once per scan from the second scan on; time_valid = 1; upd pulses exactly 6 times total.
- Blink filter:
  - Stimulus: digit 2 alternates F2 / 00 every scan, STABLE_CNT=2.
  - Response: digits[15:12] stays 3 and digit_blank[2] = 0. Then hold digit 2 at 00 for 2 scans: digit_blank[2] = 1 and upd pulses.
- Illegal and range:
  - Stimulus: digit 1 pattern 8'h81; separately, hours 2,5 (DA, B6).
  - Response: digits[19:16] = E and time_valid = 0; hours 25 gives time_valid = 0.
- Select error:
  - Stimulus: seg_com = 8'b0011_1111 for one cycle.
  - Response: com_err pulses 2 cycles later; digits unchanged.
- Link loss:
  - Stimulus: hold seg_com = FF for 64 cycles (LOST_TIMEOUT=64).
  - Response: link_lost = 1 and digits are retained. One valid select then clears link_lost.
- Async reset:
  - Stimulus: assert rst mid-frame between clk edges.
  - Response: outputs take reset values at once; after release, frame_done first fires only after all six digits are re-accepted.

Source files
------------

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: snoops a multiplexed 7-segment scan bus and rebuilds
// the displayed HH:MM:SS digits as BCD, filtering blink and glitch frames.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   seg_com[7:0]      active-low one-hot digit select (bit7 = digit0)
//   seg_data[7:0]     segments {a,b,c,d,e,f,g,dp}, active-high
//   digits[23:0]      captured BCD, digit0 in [23:20] .. digit5 in [3:0]
//   digit_blank[5:0]  digit i last accepted a blank pattern
//   time_valid        digits form a legal 00:00:00..23:59:59 time
//   frame_done        pulse: all six digits accepted in one frame
//   upd               pulse: a digit register changed
//   com_err           pulse: more than one select line low
//   link_lost         level: no valid select for LOST_TIMEOUT cycles
module seg_scan_capture #(
  parameter int STABLE_CNT   = 2,
  parameter int LOST_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  seg_com,
  input  logic [7:0]  seg_data,
  output logic [23:0] digits,
  output logic [5:0]  digit_blank,
  output logic        time_valid,
  output logic        frame_done,
  output logic        upd,
  output logic        com_err,
  output logic        link_lost
);

  localparam logic [3:0]  L_STB  = 4'(STABLE_CNT);
  localparam logic [11:0] L_LOST = 12'(LOST_TIMEOUT);

  logic [7:0]  r_com;
  logic [7:0]  r_data;
  logic [3:0]  r_cnt  [6];
  logic [7:0]  r_last [6];
  logic        r_acc;
  logic [2:0]  r_acc_idx;
  logic [7:0]  r_acc_pat;
  logic [4:0]  r_seen;
  logic [11:0] r_tmr;

  logic [7:0]  w_inv;
  logic        w_one;
  logic        w_multi;
  logic [2:0]  w_idx;
  logic        w_sel;
  logic [7:0]  w_pat;
  logic        w_same;
  logic [3:0]  w_cur;
  logic [3:0]  w_nxt;
  logic        w_hit;
  logic [3:0]  w_val;
  logic        w_blank;

  // Stage 2 classification of the registered select sample
  assign w_inv   = ~r_com;
  assign w_one   = (w_inv != 8'd0) &&
                   ((w_inv & (w_inv - 8'd1)) == 8'd0);
  assign w_multi = (w_inv != 8'd0) && !w_one;
  assign w_sel   = w_one && (w_idx < 3'd6);
  assign w_pat   = r_data & 8'hFE;

  always_comb begin
    w_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (w_inv[7-k]) w_idx = 3'(k);
    end
  end

  // Stability filter next-state for the selected digit
  always_comb begin
    w_same = 1'b0;
    w_cur  = 4'd0;
    for (int i = 0; i < 6; i++) begin
      if (w_idx == 3'(i)) begin
        w_same = (r_last[i] == w_pat);
        w_cur  = r_cnt[i];
      end
    end
    if (!w_same)
      w_nxt = 4'd1;
    else if (w_cur == L_STB)
      w_nxt = L_STB;
    else
      w_nxt = w_cur + 4'd1;
    w_hit = w_sel && (w_nxt == L_STB);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_com     <= 8'hFF;
      r_data    <= 8'h00;
      com_err   <= 1'b0;
      link_lost <= 1'b1;
      r_tmr     <= 12'd0;
      r_acc     <= 1'b0;
      r_acc_idx <= 3'd0;
      r_acc_pat <= 8'h00;
      for (int i = 0; i < 6; i++) begin
        r_cnt[i]  <= 4'd0;
        r_last[i] <= 8'h00;
      end
    end else begin
      r_com   <= seg_com;
      r_data  <= seg_data;
      com_err <= w_multi;
      // Dropped (multi-select) samples are not activity
      if (w_one) begin
        r_tmr     <= 12'd0;
        link_lost <= 1'b0;
      end else if (r_tmr != L_LOST) begin
        r_tmr <= r_tmr + 12'd1;
        if (r_tmr + 12'd1 == L_LOST) link_lost <= 1'b1;
      end else begin
        link_lost <= 1'b1;
      end
      if (w_sel) begin
        for (int i = 0; i < 6; i++) begin
          if (w_idx == 3'(i)) begin
            r_cnt[i] <= w_nxt;
            if (!w_same) r_last[i] <= w_pat;
          end
        end
      end
      r_acc     <= w_hit;
      r_acc_idx <= w_idx;
      r_acc_pat <= w_pat;
    end
  end

  // Segment pattern to BCD; dp already masked
  always_comb begin
    w_blank = 1'b0;
    case (r_acc_pat)
      8'hFC:   w_val = 4'd0;
      8'h60:   w_val = 4'd1;
      8'hDA:   w_val = 4'd2;
      8'hF2:   w_val = 4'd3;
      8'h66:   w_val = 4'd4;
      8'hB6:   w_val = 4'd5;
      8'hBE:   w_val = 4'd6;
      8'hE0:   w_val = 4'd7;
      8'hFE:   w_val = 4'd8;
      8'hF6:   w_val = 4'd9;
      8'h00: begin
        w_val   = 4'hF;
        w_blank = 1'b1;
      end
      default: w_val = 4'hE;
    endcase
  end

  // Stage 3: commit accepted digit, frame tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= 24'hFFFFFF;
      digit_blank <= 6'b111111;
      frame_done  <= 1'b0;
      upd         <= 1'b0;
      r_seen      <= 5'd0;
    end else begin
      frame_done <= 1'b0;
      upd        <= 1'b0;
      if (r_acc) begin
        for (int i = 0; i < 6; i++) begin
          if (r_acc_idx == 3'(i)) begin
            if (w_blank) begin
              digit_blank[i] <= 1'b1;
              if (!digit_blank[i]) upd <= 1'b1;
            end else begin
              digits[23-4*i -: 4] <= w_val;
              digit_blank[i]      <= 1'b0;
              if (digit_blank[i] ||
                  digits[23-4*i -: 4] != w_val)
                upd <= 1'b1;
            end
          end
        end
        if (r_acc_idx == 3'd5) begin
          frame_done <= &r_seen;
          r_seen     <= 5'd0;
        end else begin
          for (int i = 0; i < 5; i++) begin
            if (r_acc_idx == 3'(i)) r_seen[i] <= 1'b1;
          end
        end
      end
    end
  end

  logic [3:0] w_d0, w_d1, w_d2, w_d3, w_d4, w_d5;
  logic       w_dec;

  assign {w_d0, w_d1, w_d2, w_d3, w_d4, w_d5} = digits;
  assign w_dec = (w_d0 <= 4'd9) && (w_d1 <= 4'd9) &&
                 (w_d2 <= 4'd9) && (w_d3 <= 4'd9) &&
                 (w_d4 <= 4'd9) && (w_d5 <= 4'd9);

  assign time_valid = w_dec && (digit_blank == 6'd0) &&
                      ((w_d0 < 4'd2) ||
                       (w_d0 == 4'd2 && w_d1 <= 4'd3)) &&
                      (w_d2 <= 4'd5) && (w_d4 <= 4'd5);

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed bench for seg_scan_capture.
// Scans 7-segment frames and checks the rebuilt time and status flags.
module tb_seg_scan_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  seg_com;
  logic [7:0]  seg_data;
  logic [23:0] digits;
  logic [5:0]  digit_blank;
  logic        time_valid;
  logic        frame_done;
  logic        upd;
  logic        com_err;
  logic        link_lost;

  int errors = 0;
  int checks = 0;
  int n_upd  = 0;
  int n_fd   = 0;

  localparam logic [47:0] P_123456 = 48'h60DAF266B6BE;
  localparam logic [47:0] P_BLINK  = 48'h60DA0066B6BE;
  localparam logic [47:0] P_ILL    = 48'h6081F266B6BE;
  localparam logic [47:0] P_253456 = 48'hDAB6F266B6BE;
  localparam logic [47:0] P_235959 = 48'hDAF3B6F6B6F6;

  seg_scan_capture #(
    .STABLE_CNT(2),
    .LOST_TIMEOUT(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seg_com(seg_com),
    .seg_data(seg_data),
    .digits(digits),
    .digit_blank(digit_blank),
    .time_valid(time_valid),
    .frame_done(frame_done),
    .upd(upd),
    .com_err(com_err),
    .link_lost(link_lost)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (upd) n_upd++;
    if (frame_done) n_fd++;
  end

  task automatic scan(input logic [47:0] p, input int n);
    logic [7:0] one;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      one      = 8'h80;
      seg_com  = ~(one >> i);
      seg_data = (i < 6) ? p[47-8*i -: 8] : 8'h00;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      seg_com  = 8'hFF;
      seg_data = 8'h00;
    end
  endtask

  task automatic test_reset;
    rst      = 1'b1;
    seg_com  = 8'hFF;
    seg_data = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if (digits !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL reset_digits got %h exp ffffff", digits);
    end
    checks++;
    if (digit_blank !== 6'b111111) begin
      errors++;
      $display("FAIL reset_blank got %b exp 111111", digit_blank);
    end
    checks++;
    if ({time_valid, frame_done, upd, com_err, link_lost} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00001",
               {time_valid, frame_done, upd, com_err, link_lost});
    end
    rst = 1'b0;
    idle(4);
    n_upd = 0;
    n_fd  = 0;
  endtask

  task automatic test_normal;
    scan(P_123456, 8);
    checks++;
    if (n_fd !== 0 || digits !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL normal_scan1 got fd=%0d dig=%h exp fd=0 dig=ffffff",
               n_fd, digits);
    end
    scan(P_123456, 8);
    scan(P_123456, 8);
    idle(4);
    checks++;
    if (digits !== 24'h123456) begin
      errors++;
      $display("FAIL normal_digits got %h exp 123456", digits);
    end
    checks++;
    if (digit_blank !== 6'd0 || time_valid !== 1'b1) begin
      errors++;
      $display("FAIL normal_valid got blank=%b tv=%b exp 000000/1",
               digit_blank, time_valid);
    end
    checks++;
    if (n_upd !== 6) begin
      errors++;
      $display("FAIL normal_upd got %0d exp 6", n_upd);
    end
    checks++;
    if (n_fd !== 2) begin
      errors++;
      $display("FAIL normal_frames got %0d exp 2", n_fd);
    end
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL normal_link got %b exp 0", link_lost);
    end
  endtask

  task automatic test_blink;
    n_upd = 0;
    for (int k = 0; k < 2; k++) begin
      scan(P_BLINK, 8);
      scan(P_123456, 8);
    end
    idle(4);
    checks++;
    if (digits[15:12] !== 4'd3 || digit_blank[2] !== 1'b0 || n_upd !== 0) begin
      errors++;
      $display("FAIL blink_filter got d=%h b=%b upd=%0d exp 3/0/0",
               digits[15:12], digit_blank[2], n_upd);
    end
    scan(P_BLINK, 8);
    scan(P_BLINK, 8);
    idle(4);
    checks++;
    if (digit_blank[2] !== 1'b1 || digits[15:12] !== 4'd3 || n_upd !== 1) begin
      errors++;
      $display("FAIL blink_blank got b=%b d=%h upd=%0d exp 1/3/1",
               digit_blank[2], digits[15:12], n_upd);
    end
    checks++;
    if (time_valid !== 1'b0) begin
      errors++;
      $display("FAIL blink_tv got %b exp 0", time_valid);
    end
  endtask

  task automatic test_illegal_range;
    scan(P_ILL, 8);
    scan(P_ILL, 8);
    idle(4);
    checks++;
    if (digits !== 24'h1E3456 || time_valid !== 1'b0) begin
      errors++;
      $display("FAIL illegal_digit got %h tv=%b exp 1e3456 tv=0",
               digits, time_valid);
    end
    scan(P_253456, 8);
    scan(P_253456, 8);
    idle(4);
    checks++;
    if (digits !== 24'h253456 || time_valid !== 1'b0) begin
      errors++;
      $display("FAIL range_hours got %h tv=%b exp 253456 tv=0",
               digits, time_valid);
    end
    scan(P_235959, 8);
    scan(P_235959, 8);
    idle(4);
    checks++;
    if (digits !== 24'h235959 || time_valid !== 1'b1) begin
      errors++;
      $display("FAIL range_max got %h tv=%b exp 235959 tv=1",
               digits, time_valid);
    end
  endtask

  task automatic test_com_err;
    @(negedge clk);
    seg_com  = 8'h3F;
    seg_data = 8'hFE;
    @(posedge clk);
    #1;
    checks++;
    if (com_err !== 1'b0) begin
      errors++;
      $display("FAIL com_err_early got %b exp 0", com_err);
    end
    @(negedge clk);
    seg_com  = 8'hFF;
    seg_data = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if (com_err !== 1'b1) begin
      errors++;
      $display("FAIL com_err_pulse got %b exp 1", com_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (com_err !== 1'b0 || digits !== 24'h235959) begin
      errors++;
      $display("FAIL com_err_after got ce=%b dig=%h exp 0/235959",
               com_err, digits);
    end
  endtask

  task automatic test_link_loss;
    @(negedge clk);
    seg_com = 8'hFD;
    @(negedge clk);
    seg_com = 8'hFF;
    repeat (60) @(negedge clk);
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL link_early got %b exp 0", link_lost);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (link_lost !== 1'b1 || digits !== 24'h235959) begin
      errors++;
      $display("FAIL link_lost got %b dig=%h exp 1/235959",
               link_lost, digits);
    end
    seg_com = 8'hFE;
    @(posedge clk);
    #1;
    checks++;
    if (link_lost !== 1'b1) begin
      errors++;
      $display("FAIL link_latency got %b exp 1", link_lost);
    end
    @(negedge clk);
    seg_com = 8'hFF;
    @(posedge clk);
    #1;
    checks++;
    if (link_lost !== 1'b0) begin
      errors++;
      $display("FAIL link_clear got %b exp 0", link_lost);
    end
  endtask

  task automatic test_async_reset;
    scan(P_123456, 4);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (digits !== 24'hFFFFFF || digit_blank !== 6'b111111) begin
      errors++;
      $display("FAIL arst_regs got %h/%b exp ffffff/111111",
               digits, digit_blank);
    end
    checks++;
    if ({time_valid, link_lost} !== 2'b01) begin
      errors++;
      $display("FAIL arst_flags got %b exp 01", {time_valid, link_lost});
    end
    @(negedge clk);
    rst     = 1'b0;
    seg_com = 8'hFF;
    n_fd    = 0;
    n_upd   = 0;
    scan(P_123456, 8);
    checks++;
    if (n_fd !== 0 || digits !== 24'hFFFFFF) begin
      errors++;
      $display("FAIL arst_scan1 got fd=%0d dig=%h exp 0/ffffff",
               n_fd, digits);
    end
    scan(P_123456, 8);
    idle(4);
    checks++;
    if (n_fd !== 1 || digits !== 24'h123456 || n_upd !== 6) begin
      errors++;
      $display("FAIL arst_recap got fd=%0d dig=%h upd=%0d exp 1/123456/6",
               n_fd, digits, n_upd);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_blink();
    test_illegal_range();
    test_com_err();
    test_link_loss();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
